// File: rtl/sipo_frame_rx_if.sv
// sipo_frame_rx_if: serial line in, parallel valid/ready word out, error pulses
interface sipo_frame_rx_if #(parameter int DATA_W = 8);
  logic in;
  logic ready;
  logic [DATA_W-1:0] data_out;
  logic valid;
  logic overrun;
  logic frame_err;
  modport master(input in, ready, output data_out, valid, overrun, frame_err);
  modport slave(output in, ready, input data_out, valid, overrun, frame_err);
endinterface

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: serial frame receiver with held valid/ready word; define PARITY_RX_EN for even-parity checking
module sipo_frame_rx #(parameter int DATA_W = 8) (
  input logic clk,
  input logic rst,
  sipo_frame_rx_if.master bus
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d, data_q, data_d;
  logic valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d, good, hold;
`ifdef PARITY_RX_EN
  localparam state_t AFTER_DATA = PARITY;
  logic par_q, par_d;
  assign good = !bus.in && (par_q == ^sh_q);
`else
  localparam state_t AFTER_DATA = STOP;
  assign good = !bus.in;
`endif
  assign hold = valid_q && !bus.ready;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    data_d = data_q;
    valid_d = hold;
    ovr_d = 1'b0;
    ferr_d = 1'b0;
`ifdef PARITY_RX_EN
    par_d = par_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = bus.in ? DATA : IDLE;
        cnt_d = '0;
      end
      DATA: begin
        sh_d = {bus.in, sh_q[DATA_W-1:1]};
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(DATA_W - 1)) ? AFTER_DATA : DATA;
      end
      PARITY: begin
`ifdef PARITY_RX_EN
        par_d = bus.in;
`endif
        state_d = STOP;
      end
      STOP: begin
        state_d = IDLE;
        ferr_d = !good;
        ovr_d = good && hold;
        data_d = (good && !hold) ? sh_q : data_q;
        valid_d = hold || good;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef PARITY_RX_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ovr_q <= ovr_d;
      ferr_q <= ferr_d;
`ifdef PARITY_RX_EN
      par_q <= par_d;
`endif
    end
  end
  assign bus.data_out = data_q;
  assign bus.valid = valid_q;
  assign bus.overrun = ovr_q;
  assign bus.frame_err = ferr_q;
endmodule
